sdram_arbiter: RTL

Parametrised N-client arbiter that replaces the fixed three-way SDRAM mux and its hard-wired select logic in front of the SDRAM controller. Clients (memory initialiser, frame reader, fractal engines, ...) raise a request and receive a one-hot grant. The arbiter steers the granted client's command, address and write data to the controller, and routes read-valid and write-done back to the owner. It adds round-robin fairness, an urgent-client override (frame reader), timed preemption and a guaranteed NOP gap between owners.

---
 rtl/sdram_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// N-client SDRAM arbiter: round-robin with urgent override, advisory timed preemption
// and a fixed NOP gap between owners; steers the owner's request to the controller.
module sdram_arbiter #(
   parameter int NUM_CLIENTS   = 4,
   parameter int CMD_WIDTH     = 2,
   parameter int ADDR_WIDTH    = 22,
   parameter int DATA_WIDTH    = 32,
   parameter int URGENT_CLIENT = 1,
   parameter int URGENT_EN     = 1,
   parameter int HOLD_MAX      = 256,
   parameter int GAP_CYCLES    = 1
) (
   input  logic                              i_Clk,
   input  logic                              i_Reset,
   input  logic [NUM_CLIENTS-1:0]            i_Req,
   input  logic [NUM_CLIENTS*CMD_WIDTH-1:0]  i_Command,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] i_Address,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] i_Data_Write,
   output logic [NUM_CLIENTS-1:0]            o_Grant,
   output logic [NUM_CLIENTS-1:0]            o_Preempt,
   output logic [CMD_WIDTH-1:0]              o_Command,
   output logic [ADDR_WIDTH-1:0]             o_Data_Address,
   output logic [DATA_WIDTH-1:0]             o_Data_Write,
   input  logic                              i_Data_Read_Valid,
   input  logic                              i_Data_Write_Done,
   output logic [NUM_CLIENTS-1:0]            o_Data_Read_Valid,
   output logic [NUM_CLIENTS-1:0]            o_Data_Write_Done,
   output logic [$clog2(NUM_CLIENTS)-1:0]    o_Owner
);

   localparam int OW       = $clog2(NUM_CLIENTS);
   localparam int HOLD_LIM = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
   localparam int HCW      = (HOLD_LIM > 0) ? $clog2(HOLD_LIM + 1) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic [1:0]             state;
   logic [OW-1:0]          rr_ptr;
   logic [HCW-1:0]         hold_cnt;
   logic [3:0]             gap_cnt;
   logic [OW-1:0]          winner;
   logic                   found;
   int                     idx;
   logic [NUM_CLIENTS-1:0] owner_onehot;
   logic                   owner_req;
   logic                   rivals;
   logic                   hold_hit;
   logic                   urgent_hit;

   // Winner: first requester at or above the RR pointer (wrapping), urgent client overrides.
   always_comb begin
      winner = rr_ptr;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_CLIENTS;
         if (!found && i_Req[idx]) begin
            found  = 1'b1;
            winner = OW'(idx);
         end
      end
      if (URGENT_EN != 0 && i_Req[URGENT_CLIENT]) winner = OW'(URGENT_CLIENT);
   end

   assign owner_onehot = NUM_CLIENTS'(1) << o_Owner;
   assign owner_req    = i_Req[o_Owner];
   assign rivals       = |(i_Req & ~owner_onehot);
   assign hold_hit     = (HOLD_MAX > 0) && (hold_cnt == HCW'(HOLD_LIM)) && rivals;
   assign urgent_hit   = (URGENT_EN != 0) && (o_Owner != OW'(URGENT_CLIENT)) && i_Req[URGENT_CLIENT];

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state     <= ST_IDLE;
         o_Grant   <= '0;
         o_Preempt <= '0;
         o_Owner   <= '0;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|i_Req) begin
                  o_Grant  <= NUM_CLIENTS'(1) << winner;
                  o_Owner  <= winner;
                  hold_cnt <= '0;
                  state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!owner_req) begin
                  o_Grant   <= '0;
                  o_Preempt <= '0;
                  rr_ptr    <= (o_Owner == OW'(NUM_CLIENTS - 1)) ? '0 : OW'(o_Owner + 1'b1);
                  hold_cnt  <= '0;
                  gap_cnt   <= '0;
                  state     <= ST_GAP;
               end else begin
                  // Counter saturates at the limit so the preempt condition stays true.
                  if (hold_cnt != HCW'(HOLD_LIM)) hold_cnt <= hold_cnt + 1'b1;
                  if (hold_hit || urgent_hit) o_Preempt <= owner_onehot;
               end
            end
            ST_GAP: begin
               if (gap_cnt == 4'(GAP_CYCLES - 1)) state <= ST_IDLE;
               else                               gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // o_Owner survives release, so late beats still reach the last owner.
   always_comb begin
      o_Command      = '0;
      o_Data_Address = '0;
      o_Data_Write   = '0;
      if (|o_Grant) begin
         o_Command      = i_Command[o_Owner*CMD_WIDTH +: CMD_WIDTH];
         o_Data_Address = i_Address[o_Owner*ADDR_WIDTH +: ADDR_WIDTH];
         o_Data_Write   = i_Data_Write[o_Owner*DATA_WIDTH +: DATA_WIDTH];
      end
      o_Data_Read_Valid = i_Data_Read_Valid ? owner_onehot : '0;
      o_Data_Write_Done = i_Data_Write_Done ? owner_onehot : '0;
   end

endmodule
